// File: rtl/systolic_result_writer.sv
// systolic_result_writer: streams a captured 16-lane result tile to byte-wide memory
module systolic_result_writer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              result_valid,
  input  logic [255:0]      result_in,
  input  logic [3:0]        rows,
  input  logic [3:0]        cols,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mode,
  input  logic              mem_ready,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_write_data,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [7:0]        bytes_written
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [255:0]      tile_q, tile_d;
  logic [4:0]        n_q, n_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        bw_q, bw_d;
  logic              ovr_q, ovr_d;
  logic [7:0]        prod;
  logic [4:0]        n_in;
  logic [5:0]        total;
  logic [3:0]        lane;
  logic [15:0]       lane_val;
  logic [7:0]        sat;
  logic              last;
  assign prod     = {4'd0, rows} * {4'd0, cols};
  assign n_in     = (prod > 8'd16) ? 5'd16 : prod[4:0];
  assign total    = mode_q ? {1'b0, n_q} : {n_q, 1'b0};
  assign lane     = mode_q ? bw_q[3:0] : bw_q[4:1];
  assign lane_val = tile_q[{lane, 4'b0} +: 16];
  assign sat      = ($signed(lane_val) > 16'sd127)  ? 8'h7F :
                    ($signed(lane_val) < -16'sd128) ? 8'h80 : lane_val[7:0];
  assign last     = (bw_q[5:0] + 6'd1) == total;
  assign mem_write_enable = state_q == WRITE;
  assign mem_addr         = addr_q;
  assign mem_write_data   = mode_q ? sat : (bw_q[0] ? lane_val[15:8] : lane_val[7:0]);
  assign busy             = state_q != IDLE;
  assign done             = state_q == DONE;
  assign overrun          = ovr_q;
  assign bytes_written    = bw_q;
  // Next state: capture in IDLE, advance one byte per accepted write, one-cycle DONE
  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    n_d     = n_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    bw_d    = bw_q;
    ovr_d   = ovr_q | (result_valid && state_q != IDLE);
    case (state_q)
      IDLE: if (result_valid) begin
        tile_d  = result_in;
        n_d     = n_in;
        mode_d  = mode;
        addr_d  = base_addr;
        bw_d    = 8'd0;
        state_d = (n_in == 5'd0) ? DONE : WRITE;
      end
      WRITE: if (mem_ready) begin
        addr_d  = addr_q + 1'b1;
        bw_d    = bw_q + 8'd1;
        state_d = last ? DONE : WRITE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and capture registers; reset abandons any tile in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tile_q  <= '0;
      n_q     <= '0;
      mode_q  <= 1'b0;
      addr_q  <= '0;
      bw_q    <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      n_q     <= n_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      bw_q    <= bw_d;
      ovr_q   <= ovr_d;
    end
  end
endmodule

// File: doc/systolic_result_writer.md
SYSTOLIC_RESULT_WRITER -- requirements
Module: systolic_result_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning memory address width; addresses wrap modulo 2^ADDR_W.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port result_valid  input  1  one-cycle strobe; result_in holds a complete result tile.
REQ-005 SHALL have port result_in  input  256  16 lanes of signed 16-bit results; lane i = bits [16i+15:16i].
REQ-006 SHALL have port rows  input  4  result matrix rows.
REQ-007 SHALL have port cols  input  4  result matrix columns.
REQ-008 SHALL have port base_addr  input  ADDR_W  destination address of the first byte.
REQ-009 SHALL have port mode  input  1  0 = 16-bit little-endian (two bytes per lane); 1 = saturate to signed 8-bit (one byte per lane).
REQ-010 SHALL have port mem_ready  input  1  memory accepts the presented byte this cycle.
REQ-011 SHALL have port mem_write_enable  output  1  byte write request.
REQ-012 SHALL have port mem_addr  output  ADDR_W  write address.
REQ-013 SHALL have port mem_write_data  output  8  write byte.
REQ-014 SHALL have port busy  output  1  high outside IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a tile is fully written.
REQ-016 SHALL have port overrun  output  1  sticky flag; result_valid arrived while busy.
REQ-017 SHALL have port bytes_written  output  8  bytes accepted for the current/last tile.

Function
REQ-018 SHALL implement states IDLE, WRITE, DONE.
REQ-019 In IDLE with result_valid=1, SHALL capture result_in, rows, cols, base_addr and mode into internal registers, clear bytes_written and go to WRITE; later input changes SHALL NOT affect the tile.
REQ-020 Lane count SHALL be N = min(rows*cols, 16), computed at capture; with N=0 the block SHALL go IDLE->DONE without any write.
REQ-021 Total bytes SHALL be N*2 in mode 0 and N in mode 1.
REQ-022 In WRITE, mem_write_enable SHALL be 1 in the cycle after capture, with the first byte at mem_addr = base_addr.
REQ-023 A byte SHALL be held stable (addr, data, enable) until a rising edge with mem_ready=1; that edge SHALL increment mem_addr (wrapping) and bytes_written, and advance to the next byte.
REQ-024 Mode 0 byte order SHALL be lane 0 low, lane 0 high, lane 1 low, and so on.
REQ-025 Mode 1 byte SHALL be lane value clamped: >127 -> 8'h7F, < -128 -> 8'h80, else low 8 bits.
REQ-026 On acceptance of the last byte, SHALL go to DONE with mem_write_enable deasserted in the following cycle.
REQ-027 DONE SHALL last exactly one cycle with done=1, then return to IDLE; a result_valid in DONE SHALL be ignored and set overrun.
REQ-028 result_valid in WRITE SHALL be ignored (tile not altered) and SHALL set overrun; overrun clears only on rst.
REQ-029 busy SHALL be 1 in WRITE and DONE, 0 in IDLE.
REQ-030 bytes_written SHALL hold its final value after DONE until the next capture.

Reset
REQ-031 While rst=1, SHALL force IDLE and mem_write_enable=0, mem_addr=0, mem_write_data=0, busy=0, done=0, overrun=0, bytes_written=0, and all capture registers=0, regardless of clk.
REQ-032 rst asserted mid-WRITE SHALL abandon the tile immediately with no further write; after release the block SHALL wait in IDLE for a new result_valid.

Verification
REQ-033 rows=2, cols=2, mode=0, base=8'h10, lanes 0..3 = 16'h1234,16'hABCD,16'h0001,16'hFFFF, mem_ready=1 -> writes 34@10,12@11,CD@12,AB@13,01@14,00@15,FF@16,FF@17; done at cycle 9 after capture; bytes_written=8.
REQ-034 rows=1, cols=3, mode=1, lanes 300,-500,-7 -> bytes 7F,80,F9 at base..base+2; bytes_written=3.
REQ-035 mem_ready toggling 1,0,0,1,... -> each byte held unchanged while mem_ready=0, no skipped or duplicated address.
REQ-036 base=8'hFF, mode=0, N=1 -> writes at FF then 00 (wrap); rows=0 -> done pulse with no write; rows=5, cols=5 -> N clamped to 16.
REQ-037 result_valid pulsed during WRITE -> overrun=1, output byte sequence identical to an undisturbed run; rst mid-WRITE -> mem_write_enable=0 at once, all outputs at reset values.
